// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph constants and scan FSM states
package seg7_pkg;

    // Active-low g..a patterns; bit 7 (DP) is handled separately.
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h58;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPHS [16] = '{
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
        GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - active-low segment pattern to hex value lookup
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        value = '0;
        hit   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                value = 4'(i);
                hit   = 1'b1;
            end
        end
    end

    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - qualifies multiplexed 7-segment strobes and captures per-digit hex values
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter  int N_DIGITS      = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            SEG,
    input  logic [N_DIGITS-1:0]   DIG_N,
    output logic [4*N_DIGITS-1:0] DIGITS,
    output logic [N_DIGITS-1:0]   DP,
    output logic [N_DIGITS-1:0]   VALID,
    output logic [N_DIGITS-1:0]   ERR,
    output logic                  UPD,
    output logic [IDX_W-1:0]      UPD_IDX
);

    localparam int IN_W  = N_DIGITS + 8;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);

    logic [IN_W-1:0]       in_q, in_d;
    logic [IN_W-1:0]       prev_q, prev_d;
    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   err_q, err_d;
    logic                  upd_q, upd_d;
    logic [IDX_W-1:0]      upd_idx_q, upd_idx_d;

    logic [N_DIGITS-1:0] dig_s;
    logic [7:0]          seg_s;
    logic                legal;
    logic                changed;
    logic                capture;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          dec_value;
    logic                dec_hit;
    logic                dec_blank;

    assign dig_s   = in_q[IN_W-1:8];
    assign seg_s   = in_q[7:0];
    assign legal   = $onehot(~dig_s);
    assign changed = (in_q != prev_q);

    seg7_pattern_decode u_decode (
        .seg   (seg_s[6:0]),
        .value (dec_value),
        .hit   (dec_hit),
        .blank (dec_blank)
    );

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!dig_s[i]) idx = IDX_W'(i);
        end
    end

    always_comb begin
        in_d    = {DIG_N, SEG};
        prev_d  = in_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            SETTLE: begin
                if (!changed) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (legal) begin
                    cnt_d = CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (changed && legal) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end else if (changed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Checking the next count lets STABLE_CYCLES=1 capture right after the first sample.
        if (state_d == SETTLE && cnt_d >= CNT_TGT) begin
            capture = 1'b1;
            state_d = HOLD;
        end
    end

    always_comb begin
        digits_d  = digits_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        err_d     = err_q;
        upd_d     = capture;
        upd_idx_d = capture ? idx : upd_idx_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (capture && !dig_s[i]) begin
                dp_d[i]    = ~seg_s[7];
                valid_d[i] = dec_hit;
                err_d[i]   = !dec_hit && !dec_blank;
                if (dec_hit) digits_d[4*i +: 4] = dec_value;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_q      <= '1;
            prev_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            digits_q  <= '0;
            dp_q      <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            in_q      <= in_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign DIGITS  = digits_q;
    assign DP      = dp_q;
    assign VALID   = valid_q;
    assign ERR     = err_q;
    assign UPD     = upd_q;
    assign UPD_IDX = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - directed self-checking bench for seg7_scan_reader
module tb_seg7_scan_reader;

    localparam int N = 4;

    logic           CLK   = 1'b0;
    logic           RST   = 1'b1;
    logic [7:0]     SEG   = 8'hFF;
    logic [N-1:0]   DIG_N = '1;
    logic [4*N-1:0] DIGITS;
    logic [N-1:0]   DP, VALID, ERR;
    logic           UPD;
    logic [1:0]     UPD_IDX;

    int         total   = 0;
    int         bad     = 0;
    int         upd_cnt = 0;
    int         base    = 0;
    logic [1:0] last_idx = '0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_reader #(
        .N_DIGITS      (N),
        .STABLE_CYCLES (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SEG     (SEG),
        .DIG_N   (DIG_N),
        .DIGITS  (DIGITS),
        .DP      (DP),
        .VALID   (VALID),
        .ERR     (ERR),
        .UPD     (UPD),
        .UPD_IDX (UPD_IDX)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (UPD === 1'b1) begin
            upd_cnt  = upd_cnt + 1;
            last_idx = UPD_IDX;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        step(2);
        chk("rst_digits", DIGITS, 0);
        chk("rst_dp", DP, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_err", ERR, 0);
        chk("rst_upd", UPD, 0);
        chk("rst_upd_idx", UPD_IDX, 0);
        RST = 1'b0;

        // digit 0 shows '0': capture on the 5th edge counting the first sample
        DIG_N = 4'b1110; SEG = 8'hC0; base = upd_cnt;
        step(4);
        chk("d0_early_valid", VALID, 4'b0000);
        step(1);
        chk("d0_valid", VALID, 4'b0001);
        chk("d0_digit", DIGITS[3:0], 0);
        chk("d0_dp", DP, 4'b0000);
        chk("d0_upd", UPD, 1);
        chk("d0_upd_idx", UPD_IDX, 0);
        step(5);
        chk("d0_upd_count", upd_cnt - base, 1);

        // all 16 glyphs on digit 2, DP lit on F
        DIG_N = 4'b1011; base = upd_cnt;
        for (int v = 0; v < 16; v++) begin
            SEG = {(v != 15), glyph[v]};
            step(6);
            chk($sformatf("scan_val_%0d", v), DIGITS[11:8], v);
            chk($sformatf("scan_valid_%0d", v), VALID[2], 1);
            if (v == 14) chk("scan_dp_e", DP[2], 0);
        end
        chk("scan_dp_f", DP, 4'b0100);
        chk("scan_digits", DIGITS, 16'h0F00);
        chk("scan_valid", VALID, 4'b0101);
        chk("scan_upd_count", upd_cnt - base, 16);
        chk("scan_last_idx", last_idx, 2);

        // digit 1 '5' broken by 2-cycle blank glitches: never qualifies
        DIG_N = 4'b1101; base = upd_cnt;
        repeat (8) begin
            SEG = 8'h92; step(1);
            SEG = 8'hFF; step(2);
        end
        chk("glitch_upd_count", upd_cnt - base, 0);
        chk("glitch_valid", VALID[1], 0);
        chk("glitch_err", ERR[1], 0);
        chk("glitch_digit", DIGITS[7:4], 0);

        // illegal strobes never capture
        DIG_N = 4'b1100; SEG = 8'hC0; base = upd_cnt;
        step(20);
        DIG_N = 4'b1111;
        step(20);
        chk("illegal_upd_count", upd_cnt - base, 0);
        chk("illegal_valid", VALID, 4'b0101);

        // digit 3: 'E', then blank, then unrecognised pattern
        DIG_N = 4'b0111; SEG = 8'h86; base = upd_cnt;
        step(6);
        chk("d3_e_digit", DIGITS[15:12], 4'hE);
        chk("d3_e_valid", VALID[3], 1);
        SEG = 8'hFF;
        step(6);
        chk("d3_blank_valid", VALID[3], 0);
        chk("d3_blank_err", ERR[3], 0);
        chk("d3_blank_digit", DIGITS[15:12], 4'hE);
        SEG = 8'hE3;
        step(6);
        chk("d3_miss_err", ERR[3], 1);
        chk("d3_miss_valid", VALID[3], 0);
        chk("d3_miss_digit", DIGITS[15:12], 4'hE);
        chk("d3_miss_dp", DP[3], 0);
        chk("d3_upd_count", upd_cnt - base, 3);
        chk("d3_last_idx", last_idx, 3);

        // reset two counts into SETTLE on digit 0
        DIG_N = 4'b1110; SEG = 8'hF9; base = upd_cnt;
        step(3);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("mid_rst_digits", DIGITS, 0);
        chk("mid_rst_dp", DP, 0);
        chk("mid_rst_valid", VALID, 0);
        chk("mid_rst_err", ERR, 0);
        chk("mid_rst_upd", UPD, 0);
        step(4);
        chk("post_rst_early", VALID, 4'b0000);
        step(1);
        chk("post_rst_valid", VALID, 4'b0001);
        chk("post_rst_digit", DIGITS[3:0], 1);
        chk("post_rst_upd", UPD, 1);
        step(3);
        chk("post_rst_upd_count", upd_cnt - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
